// File: rtl/rat_pkg.sv
// rtl/rat_pkg.sv - Shared RAT CPU constants and types.
//
// Purpose : program-counter width, call-stack depth, PC mux select codes
//           and the program-counter value type.
// Ports   : none (package).
package rat_pkg;

    localparam int PC_W             = 10;
    localparam int CALL_STACK_DEPTH = 16;

    // PC input mux selects; the call stack feeds select 1.
    localparam logic [1:0] PC_SEL_IMMED = 2'd0;
    localparam logic [1:0] PC_SEL_STACK = 2'd1;
    localparam logic [1:0] PC_SEL_INTR  = 2'd2;   // interrupt vector 0x3FF
    localparam logic [1:0] PC_SEL_ZERO  = 2'd3;

    typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/call_stack_mem.sv
// rtl/call_stack_mem.sv - Return-address register file for the call stack.
//
// Purpose : DEPTH x WIDTH storage, one synchronous write port and one
//           asynchronous read port. Contents are not reset.
// Ports   : i_clk    - clock
//           i_we     - write enable
//           i_waddr  - write address
//           i_wdata  - write data
//           i_raddr  - read address
//           o_rdata  - read data (combinational)
module call_stack_mem
    import rat_pkg::*;
#(
    parameter int WIDTH = PC_W,
    parameter int DEPTH = CALL_STACK_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack.sv
// rtl/call_stack.sv - Hardware return-address stack for the RAT CPU.
//
// Purpose : saves PC_COUNT+1 on PUSH (CALL) and presents the top entry on
//           FROM_STACK so RET/RETI can load the PC in the POP cycle.
// Ports   : CLK        - clock, rising edge
//           RST        - synchronous active-high reset
//           PUSH       - save return address
//           POP        - discard top entry
//           PC_COUNT   - current PC
//           FROM_STACK - top-of-stack return address (0 when empty)
//           EMPTY/FULL - level status
//           LEVEL      - number of valid entries
//           OVERFLOW   - push rejected (stack full)
//           UNDERFLOW  - pop rejected (stack empty)
// Macro   : CALL_STACK_STICKY_ERR_EN - error flags hold until RST.
module call_stack
    import rat_pkg::*;
#(
    parameter int PC_W  = rat_pkg::PC_W,
    parameter int DEPTH = CALL_STACK_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     PUSH,
    input  logic                     POP,
    input  logic [PC_W-1:0]          PC_COUNT,
    output logic [PC_W-1:0]          FROM_STACK,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [LW-1:0]   r_level;
    logic            r_ovf;
    logic            r_unf;

    logic [LW-1:0]   w_level_nxt;
    logic [LW-1:0]   w_level_m1;
    logic            w_empty;
    logic            w_full;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [AW-1:0]   w_raddr;
    logic [PC_W-1:0] w_ret;
    logic [PC_W-1:0] w_rdata;
    logic            w_ovf_req;
    logic            w_unf_req;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_level_m1 = r_level - LW'(1);
    assign w_ret      = PC_COUNT + PC_W'(1);   // wraps 0x3FF -> 0x000
    assign w_raddr    = w_level_m1[AW-1:0];

    always_comb begin
        w_level_nxt = r_level;
        w_we        = 1'b0;
        w_waddr     = r_level[AW-1:0];
        w_ovf_req   = 1'b0;
        w_unf_req   = 1'b0;
        if (PUSH && POP) begin
            w_we = 1'b1;
            if (w_empty) begin
                // Push proceeds into slot 0; the pop has nothing to remove.
                w_level_nxt = LW'(1);
                w_unf_req   = 1'b1;
            end else begin
                // Replace top in place; works when full too.
                w_waddr = w_raddr;
            end
        end else if (PUSH) begin
            if (w_full) begin
                w_ovf_req = 1'b1;
            end else begin
                w_we        = 1'b1;
                w_level_nxt = r_level + LW'(1);
            end
        end else if (POP) begin
            if (w_empty) begin
                w_unf_req = 1'b1;
            end else begin
                w_level_nxt = w_level_m1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
`ifdef CALL_STACK_STICKY_ERR_EN
            r_ovf   <= r_ovf | w_ovf_req;
            r_unf   <= r_unf | w_unf_req;
`else
            r_ovf   <= w_ovf_req;
            r_unf   <= w_unf_req;
`endif
        end
    end

    // Reset wins, so a write requested alongside RST must not land either.
    call_stack_mem #(
        .WIDTH (PC_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_we && !RST),
        .i_waddr (w_waddr),
        .i_wdata (w_ret),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Gating by EMPTY keeps unwritten storage from ever reaching the PC.
    assign FROM_STACK = w_empty ? '0 : w_rdata;
    assign EMPTY      = w_empty;
    assign FULL       = w_full;
    assign LEVEL      = r_level;
    assign OVERFLOW   = r_ovf;
    assign UNDERFLOW  = r_unf;

endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - Directed self-checking bench for call_stack.
module tb_call_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic [9:0] pc_count;
    logic [9:0] from_stack;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    call_stack #(.PC_W(10), .DEPTH(16)) dut (
        .CLK        (clk),
        .RST        (rst),
        .PUSH       (push),
        .POP        (pop),
        .PC_COUNT   (pc_count),
        .FROM_STACK (from_stack),
        .EMPTY      (empty),
        .FULL       (full),
        .LEVEL      (level),
        .OVERFLOW   (overflow),
        .UNDERFLOW  (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after an edge; checks between calls see post-edge state.
    task automatic drive(input logic r, input logic pu, input logic po, input logic [9:0] pc);
        rst = r; push = pu; pop = po; pc_count = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic pu, input logic po, input logic [9:0] pc);
        drive(r, pu, po, pc);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'h000);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 10'h000);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'h000);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_from", from_stack, 10'h000);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        tick();
        chk("idle_level", level, 0);
        chk("idle_from", from_stack, 10'h000);

        // Three calls, last one wraps.
        cyc(1'b0, 1'b1, 1'b0, 10'h010);
        chk("push1_from", from_stack, 10'h011);
        cyc(1'b0, 1'b1, 1'b0, 10'h020);
        cyc(1'b0, 1'b1, 1'b0, 10'h3FF);
        chk("push3_level", level, 3);
        chk("push3_from_wrap", from_stack, 10'h000);
        chk("push3_empty", empty, 0);

        // Returns: FROM_STACK sampled in the POP cycle, before the edge.
        drive(1'b0, 1'b0, 1'b1, 10'h000);
        chk("pop1_from", from_stack, 10'h000);
        tick();
        chk("pop2_from", from_stack, 10'h021);
        tick();
        chk("pop3_from", from_stack, 10'h011);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'h000);
        chk("pop_done_empty", empty, 1);
        chk("pop_done_level", level, 0);
        chk("pop_done_from", from_stack, 10'h000);
        chk("pop_done_unf", underflow, 0);

        // Fill to capacity.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 10'h100 + 10'(i));
        end
        chk("fill_full", full, 1);
        chk("fill_level", level, 16);
        chk("fill_from", from_stack, 10'h110);
        chk("fill_ovf", overflow, 0);
        cyc(1'b0, 1'b1, 1'b0, 10'h200);
        chk("ovf_flag", overflow, 1);
        chk("ovf_level", level, 16);
        chk("ovf_from", from_stack, 10'h110);
        tick();
`ifdef CALL_STACK_STICKY_ERR_EN
        chk("ovf_sticky", overflow, 1);
`else
        chk("ovf_pulse_end", overflow, 0);
`endif
        cyc(1'b0, 1'b1, 1'b1, 10'h300);
        chk("full_swap_from", from_stack, 10'h301);
        chk("full_swap_level", level, 16);
        chk("full_swap_full", full, 1);
`ifndef CALL_STACK_STICKY_ERR_EN
        chk("full_swap_ovf", overflow, 0);
`endif

        // Underflow on an empty pop.
        cyc(1'b1, 1'b0, 1'b0, 10'h000);
        chk("rst2_ovf", overflow, 0);
        cyc(1'b0, 1'b0, 1'b1, 10'h000);
        chk("unf_flag", underflow, 1);
        chk("unf_level", level, 0);
`ifdef CALL_STACK_STICKY_ERR_EN
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("unf_sticky", underflow, 1);
        end
        cyc(1'b1, 1'b0, 1'b0, 10'h000);
        chk("unf_sticky_rst", underflow, 0);
`else
        tick();
        chk("unf_pulse_end", underflow, 0);
`endif

        // Simultaneous push+pop on empty.
        cyc(1'b0, 1'b1, 1'b1, 10'h040);
        chk("pp_empty_level", level, 1);
        chk("pp_empty_from", from_stack, 10'h041);
        chk("pp_empty_unf", underflow, 1);
        tick();
`ifndef CALL_STACK_STICKY_ERR_EN
        chk("pp_empty_unf_end", underflow, 0);
`endif
        // Replace top on a non-full, non-empty stack.
        cyc(1'b0, 1'b1, 1'b1, 10'h07E);
        chk("pp_mid_level", level, 1);
        chk("pp_mid_from", from_stack, 10'h07F);

        // Reset together with push discards everything.
        cyc(1'b1, 1'b0, 1'b0, 10'h000);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 10'h050 + 10'(i));
        end
        chk("five_level", level, 5);
        chk("five_from", from_stack, 10'h055);
        cyc(1'b1, 1'b1, 1'b0, 10'h123);
        chk("rstpush_level", level, 0);
        chk("rstpush_empty", empty, 1);
        chk("rstpush_from", from_stack, 10'h000);
        cyc(1'b0, 1'b1, 1'b0, 10'h0AA);
        chk("after_rst_push", from_stack, 10'h0AB);
        chk("after_rst_level", level, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware return-address stack for the RAT CPU.
- Sits beside the program-counter stage and produces the 10-bit FROM_STACK operand consumed by the PC input mux (select 1).
- On CALL, the control unit pulses PUSH and the block saves PC_COUNT+1.
- On RET/RETI, the control unit pulses POP and loads the PC from FROM_STACK in the same cycle.

Parameters:
- PC_W, 10, program-counter/address width.
- DEPTH, 16, number of return-address entries (power of two, 2..256).

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- PUSH  input  1  save return address this cycle (CALL).
- POP  input  1  discard top entry this cycle (RET/RETI).
- PC_COUNT  input  PC_W  current PC value from the program counter.
- FROM_STACK  output  PC_W  top-of-stack return address, feeds PC mux D1.
- EMPTY  output  1  no valid entries.
- FULL  output  1  DEPTH valid entries.
- LEVEL  output  $clog2(DEPTH)+1  number of valid entries.
- OVERFLOW  output  1  push rejected because stack was full.
- UNDERFLOW  output  1  pop rejected because stack was empty.

Behaviour:
- Reset (RST=1 at a rising edge):
  - LEVEL=0, EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0, FROM_STACK=0.
  - Storage contents are don't-care after reset.
- Return address = PC_COUNT+1, truncated to PC_W bits, so 0x3FF wraps to 0x000.
- FROM_STACK is combinational from registered state:
  - Equals mem[LEVEL-1]; forced to 0 when EMPTY.
  - It reflects the pre-edge top entry. The PC therefore loads it in the same cycle POP is asserted (zero-latency RET).
- EMPTY = (LEVEL==0), FULL = (LEVEL==DEPTH); both combinational from LEVEL.
- Per-cycle actions, evaluated at the rising edge:
  - PUSH only, not full: mem[LEVEL] <= PC_COUNT+1; LEVEL increments.
  - PUSH only, full: no write, LEVEL unchanged, OVERFLOW error.
  - POP only, not empty: LEVEL decrements (entry not cleared).
  - POP only, empty: LEVEL unchanged, UNDERFLOW error.
  - PUSH and POP, not empty (full included): mem[LEVEL-1] <= PC_COUNT+1 (top replaced), LEVEL unchanged, no error.
  - PUSH and POP, empty: push executes (LEVEL becomes 1), pop ignored, UNDERFLOW error.
  - Neither asserted: hold.
- Error flags are registered single-cycle pulses, asserted in the cycle after the offending request.
- RST has priority over PUSH/POP in the same cycle. A reset mid-sequence discards all entries.
- No X propagation: FROM_STACK never reads an unwritten location, because reads are gated by EMPTY.

Optional Feature:
- Macro: CALL_STACK_STICKY_ERR_EN.
- Defined: OVERFLOW/UNDERFLOW are sticky; once set they stay 1 until RST.
- Undefined: single-cycle pulses as described in Behaviour.
- Stack data behaviour is identical in both builds.

Decomposition:
- Package rat_pkg:
  - PC_W=10.
  - CALL_STACK_DEPTH=16.
  - PC mux select constants: PC_SEL_IMMED=2'd0, PC_SEL_STACK=2'd1, PC_SEL_INTR=2'd2 (vector 0x3FF), PC_SEL_ZERO=2'd3.
  - typedef pc_t = logic [PC_W-1:0].
- One sub-module, call_stack_mem:
  - DEPTH x PC_W register file, one synchronous write port, one asynchronous read port.
  - Pointer, LEVEL and flag logic stay in call_stack.

Test Plan:
- Reset then idle: LEVEL=0, EMPTY=1, FROM_STACK=0x000, no error flags.
- PUSH with PC_COUNT=0x010, then 0x020, then 0x3FF:
  - LEVEL=3, FROM_STACK=0x000 (wrap).
  - POP three times yields FROM_STACK 0x000, then 0x021, then 0x011 in the POP cycles; EMPTY=1 after.
- 16 PUSHes of 0x100..0x10F, then a 17th PUSH with 0x200:
  - FULL=1, OVERFLOW pulses one cycle, FROM_STACK stays 0x110.
  - PUSH+POP with 0x300 gives FROM_STACK=0x301, LEVEL=16, no OVERFLOW.
- POP when empty: UNDERFLOW=1 for one cycle, LEVEL=0. PUSH+POP when empty with 0x040: LEVEL=1, FROM_STACK=0x041, UNDERFLOW pulses.
- Push 5 entries, assert RST together with PUSH: LEVEL=0, EMPTY=1, FROM_STACK=0 next cycle.
- With CALL_STACK_STICKY_ERR_EN: POP when empty, then 10 idle cycles: UNDERFLOW held at 1 until RST clears it.
